pipe_stage_ctrl: RTL and testbench

// - Consumes the stall/flush requests raised by hazard detection and applies them to the 5-stage pipeline (IF, ID, EX, MEM, WB).
// - Holds one valid bit per stage and derives per-stage allowin, ready_go and register write enables.
// - Sits in the CPU top between hazard/branch logic and the stage pipeline registers.

---
 rtl/pipe_stage_ctrl_pkg.sv | 19 +
 rtl/pipe_perf_cnt.sv | 34 +++
 rtl/pipe_stage_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_stage_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline control slice.
package pipe_stage_ctrl_pkg;

    localparam int unsigned NSTAGE = 5;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } StageIdx;

    // Number of instructions killed in one cycle (0..2)
    function automatic logic [1:0] kill_cnt(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Three wrapping performance counters: stall cycles, flushed instructions, retirements.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic [1:0]       flush_inc,
    input  logic             retire_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] retired
);

    logic [CNT_W-1:0] stall_q, flush_q, retired_q;

    // Counter state; additions wrap naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= '0;
            flush_q   <= '0;
            retired_q <= '0;
        end else begin
            stall_q   <= stall_q + CNT_W'(stall_inc);
            flush_q   <= flush_q + CNT_W'(flush_inc);
            retired_q <= retired_q + CNT_W'(retire_inc);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign retired      = retired_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline valid/allowin/write-enable control for IF, ID, EX, MEM, WB.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid_i,
    input  logic              id_stall_i,
    input  logic              ex_flush_i,
    input  logic              id_flush_i,
    input  logic              ex_busy_i,
    input  logic              mem_busy_i,
    output logic [NSTAGE-1:0] stage_valid_o,
    output logic [NSTAGE-1:0] stage_we_o,
    output logic              pc_we_o,
    output logic              retire_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_count_o,
    output logic [CNT_W-1:0]  retired_o
);

    logic [NSTAGE-1:0] vld_q, vld_d;
    logic              ex_pend_q, ex_pend_d;
    logic              id_pend_q, id_pend_d;

    // Separate scalars keep the allowin chain free of self-referencing vectors
    logic aw_if, aw_id, aw_ex, aw_mem;
    logic tn_if, tn_id, tn_ex, tn_mem;
    logic ex_apply, id_apply;

    // Allowin chain from WB back to IF, then stage transfer conditions
    always_comb begin
        aw_mem = ~vld_q[ST_MEM] | ~mem_busy_i;
        aw_ex  = ~vld_q[ST_EX]  | (~ex_busy_i & aw_mem);
        aw_id  = ~vld_q[ST_ID]  | (~id_stall_i & aw_ex);
        aw_if  = ~vld_q[ST_IF]  | (fetch_valid_i & aw_id);

        tn_if  = vld_q[ST_IF]  & fetch_valid_i & aw_id;
        tn_id  = vld_q[ST_ID]  & ~id_stall_i   & aw_ex;
        tn_ex  = vld_q[ST_EX]  & ~ex_busy_i    & aw_mem;
        tn_mem = vld_q[ST_MEM] & ~mem_busy_i;

        // A flush that arrives while the target stage is blocked waits in its pending bit
        ex_apply = (ex_flush_i | ex_pend_q) & aw_ex;
        id_apply = (id_flush_i | id_pend_q) & aw_id;
    end

    // Next valid bits and pending flush bits; flush beats transfer beats hold
    always_comb begin
        vld_d = vld_q;
        if (aw_if) begin
            vld_d[ST_IF] = fetch_valid_i;
        end else if (id_apply) begin
            vld_d[ST_IF] = 1'b0;
        end
        if (aw_id) begin
            vld_d[ST_ID] = id_apply ? 1'b0 : tn_if;
        end
        if (aw_ex) begin
            vld_d[ST_EX] = ex_apply ? 1'b0 : tn_id;
        end
        if (aw_mem) begin
            vld_d[ST_MEM] = tn_ex;
        end
        vld_d[ST_WB] = tn_mem;

        ex_pend_d = aw_ex ? 1'b0 : (ex_pend_q | ex_flush_i);
        id_pend_d = aw_id ? 1'b0 : (id_pend_q | id_flush_i);
    end

    // Stage valid and pending flush registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            ex_pend_q <= 1'b0;
            id_pend_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            ex_pend_q <= ex_pend_d;
            id_pend_q <= id_pend_d;
        end
    end

    // Pipeline register write enables and status outputs
    always_comb begin
        stage_we_o         = '0;
        stage_we_o[ST_IF]  = aw_if;
        stage_we_o[ST_ID]  = aw_id & tn_if & ~id_apply;
        stage_we_o[ST_EX]  = aw_ex & tn_id & ~ex_apply;
        stage_we_o[ST_MEM] = aw_mem & tn_ex;
        stage_we_o[ST_WB]  = tn_mem;
        pc_we_o            = aw_if;
        stage_valid_o      = vld_q;
        retire_o           = vld_q[ST_WB];
    end

`ifdef PIPE_PERF_EN
    pipe_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (vld_q[ST_ID] & id_stall_i),
        .flush_inc    (kill_cnt(id_apply & vld_q[ST_IF], ex_apply & tn_id)),
        .retire_inc   (vld_q[ST_WB]),
        .stall_cycles (stall_cycles_o),
        .flush_count  (flush_count_o),
        .retired      (retired_o)
    );
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
    assign retired_o      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl; expected valid vectors go through a scoreboard queue.
module tb_pipe_stage_ctrl;

`ifdef PIPE_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        fetch_valid_i, id_stall_i, ex_flush_i, id_flush_i, ex_busy_i, mem_busy_i;
    logic [4:0]  stage_valid_o, stage_we_o;
    logic        pc_we_o, retire_o;
    logic [31:0] stall_cycles_o, flush_count_o, retired_o;

    pipe_stage_ctrl #(
        .CNT_W(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid_i  (fetch_valid_i),
        .id_stall_i     (id_stall_i),
        .ex_flush_i     (ex_flush_i),
        .id_flush_i     (id_flush_i),
        .ex_busy_i      (ex_busy_i),
        .mem_busy_i     (mem_busy_i),
        .stage_valid_o  (stage_valid_o),
        .stage_we_o     (stage_we_o),
        .pc_we_o        (pc_we_o),
        .retire_o       (retire_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o),
        .retired_o      (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  cur_v;
    logic [31:0] m_stall, m_flush, m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ":stall_cnt"}, stall_cycles_o, PerfEn ? m_stall : 32'd0);
        chk({tag, ":flush_cnt"}, flush_count_o, PerfEn ? m_flush : 32'd0);
        chk({tag, ":retired"}, retired_o, PerfEn ? m_ret : 32'd0);
    endtask

    // One cycle: drive, check combinational outputs, push expected next valids, clock, pop+check
    task automatic step(input string tag, input logic fv, input logic st, input logic exf,
                        input logic idf, input logic exb, input logic memb,
                        input logic [4:0] exp_we, input logic [4:0] exp_next, input int kills);
        logic [4:0] popped;
        fetch_valid_i = fv;
        id_stall_i    = st;
        ex_flush_i    = exf;
        id_flush_i    = idf;
        ex_busy_i     = exb;
        mem_busy_i    = memb;
        #1;
        chk({tag, ":valid_pre"}, 32'(stage_valid_o), 32'(cur_v));
        chk({tag, ":we"}, 32'(stage_we_o), 32'(exp_we));
        chk({tag, ":pc_we"}, 32'(pc_we_o), 32'(exp_we[0]));
        chk({tag, ":retire"}, 32'(retire_o), 32'(cur_v[4]));
        exp_q.push_back(exp_next);
        m_stall = m_stall + 32'(cur_v[1] & st);
        m_ret   = m_ret + 32'(cur_v[4]);
        m_flush = m_flush + 32'(kills);
        @(posedge clk);
        #1;
        popped = exp_q.pop_front();
        cur_v  = popped;
        chk({tag, ":valid_post"}, 32'(stage_valid_o), 32'(cur_v));
        chk_cnt(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1;
        {fetch_valid_i, id_stall_i, ex_flush_i, id_flush_i, ex_busy_i, mem_busy_i} = '0;
        cur_v = '0; m_stall = '0; m_flush = '0; m_ret = '0;
        #2;
        chk("rst:valid", 32'(stage_valid_o), 32'd0);
        chk("rst:pc_we", 32'(pc_we_o), 32'd1);
        chk_cnt("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming fill; WB valid after the fifth edge
        //       tag     fv st xf if xb mb  we        next      kills
        step("s1",  1, 0, 0, 0, 0, 0, 5'b00001, 5'b00001, 0);
        step("s2",  1, 0, 0, 0, 0, 0, 5'b00011, 5'b00011, 0);
        step("s3",  1, 0, 0, 0, 0, 0, 5'b00111, 5'b00111, 0);
        step("s4",  1, 0, 0, 0, 0, 0, 5'b01111, 5'b01111, 0);
        step("s5",  1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);
        step("s6",  1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);
        step("s7",  1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);
        // Load-use: ID/IF hold, EX bubble
        step("lu",  1, 1, 1, 0, 0, 0, 5'b11000, 5'b11011, 0);
        step("lu1", 1, 0, 0, 0, 0, 0, 5'b10111, 5'b10111, 0);
        step("lu2", 1, 0, 0, 0, 0, 0, 5'b01111, 5'b01111, 0);
        step("lu3", 1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);
        // Branch taken: IF instruction killed, new fetch kept
        step("br",  1, 0, 0, 1, 0, 0, 5'b11101, 5'b11101, 1);
        step("br1", 1, 0, 0, 0, 0, 0, 5'b11011, 5'b11011, 0);
        step("br2", 1, 0, 0, 0, 0, 0, 5'b10111, 5'b10111, 0);
        step("br3", 1, 0, 0, 0, 0, 0, 5'b01111, 5'b01111, 0);
        step("br4", 1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);
        // MEM back-pressure for 3 cycles, EX flush pulsed during it
        step("bp1", 1, 0, 0, 0, 0, 1, 5'b00000, 5'b01111, 0);
        step("bp2", 1, 0, 0, 0, 0, 1, 5'b00000, 5'b01111, 0);
        step("bp3", 1, 0, 1, 0, 0, 1, 5'b00000, 5'b01111, 0);
        step("fp1", 1, 0, 0, 0, 0, 0, 5'b11011, 5'b11011, 1);
        step("fp2", 1, 0, 0, 0, 0, 0, 5'b10111, 5'b10111, 0);
        step("fp3", 1, 0, 0, 0, 0, 0, 5'b01111, 5'b01111, 0);
        step("fp4", 1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);
        // Both flushes together
        step("df",  1, 0, 1, 1, 0, 0, 5'b11001, 5'b11001, 2);
        step("df1", 1, 0, 0, 0, 0, 0, 5'b10011, 5'b10011, 0);
        step("df2", 1, 0, 0, 0, 0, 0, 5'b00111, 5'b00111, 0);
        // Fetch gap empties ID, then stall with ID empty is ignored
        step("gap", 0, 0, 0, 0, 0, 0, 5'b01100, 5'b01101, 0);
        step("ise", 1, 1, 0, 0, 0, 0, 5'b11011, 5'b11011, 0);
        // EX busy
        step("xb1", 1, 0, 0, 0, 1, 0, 5'b10111, 5'b10111, 0);
        step("xb2", 1, 0, 0, 0, 1, 0, 5'b00000, 5'b00111, 0);
        step("xb3", 1, 0, 0, 0, 0, 0, 5'b01111, 5'b01111, 0);
        step("xb4", 1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);

        // Asynchronous reset mid-stream
        #2;
        rst = 1'b1;
        #1;
        cur_v = '0; m_stall = '0; m_flush = '0; m_ret = '0;
        chk("arst:valid", 32'(stage_valid_o), 32'd0);
        chk("arst:pc_we", 32'(pc_we_o), 32'd1);
        chk_cnt("arst");
        fetch_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("arst:hold", 32'(stage_valid_o), 32'd0);
        rst = 1'b0;

        step("r1",  1, 0, 0, 0, 0, 0, 5'b00001, 5'b00001, 0);
        step("r2",  1, 0, 0, 0, 0, 0, 5'b00011, 5'b00011, 0);
        step("r3",  1, 0, 0, 0, 0, 0, 5'b00111, 5'b00111, 0);
        step("r4",  1, 0, 0, 0, 0, 0, 5'b01111, 5'b01111, 0);
        step("r5",  1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);
        step("r6",  1, 0, 0, 0, 0, 0, 5'b11111, 5'b11111, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
